// File: rtl/niosii_usb_cpu_cpu_mult_seq_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier built from
// an external triple of 16x16 multiplier cells.
// Optional feature macro: NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN (unsigned high word).
package niosii_usb_cpu_cpu_mult_seq_pkg;

    localparam int DATA_W  = 32;
    localparam int HALF_W  = 16;
    // Upper bits of the 34-bit low-word partial sum that feed the high word.
    localparam int CARRY_W = 18;

    localparam logic OP_MUL    = 1'b0;
    localparam logic OP_MULXUU = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISS_LO = 3'd1,
        S_CAP_LO = 3'd2,
`ifdef NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN
        S_ISS_HI = 3'd3,
        S_CAP_HI = 3'd4,
`endif
        S_RESP   = 3'd5
    } state_t;

endpackage

// File: rtl/niosii_usb_cpu_cpu_mult_seq_comb.sv
// Combinational recombination of the three 16x16 cell products into the low
// product word and, when MULXUU support is built in, the high product word.
// Optional feature macro: NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN.
module niosii_usb_cpu_cpu_mult_seq_comb
    import niosii_usb_cpu_cpu_mult_seq_pkg::*;
(
    input  logic [DATA_W-1:0]  p1,
    input  logic [DATA_W-1:0]  p2,
    input  logic [DATA_W-1:0]  p3,
`ifdef NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN
    input  logic [CARRY_W-1:0] carry_in,
    output logic [CARRY_W-1:0] carry,
    output logic [DATA_W-1:0]  hi,
`endif
    output logic [DATA_W-1:0]  lo
);

    logic [DATA_W:0]   mid;
    logic [DATA_W+1:0] s;

    // Cross terms summed, then aligned with the upper half of lo*lo.
    always_comb begin
        mid = {1'b0, p2} + {1'b0, p3};
        s   = {{(CARRY_W){1'b0}}, p1[DATA_W-1:HALF_W]} + {1'b0, mid};
        lo  = {s[HALF_W-1:0], p1[HALF_W-1:0]};
    end

`ifdef NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN
    // p1 carries hi*hi on the second pass; add the carried-up partial sum.
    always_comb begin
        carry = s[DATA_W+1:HALF_W];
        hi    = p1 + {{(DATA_W-CARRY_W){1'b0}}, carry_in};
    end
`else
    logic unused_s_hi;
    assign unused_s_hi = ^s[DATA_W+1:HALF_W];
`endif

endmodule

// File: rtl/niosii_usb_cpu_cpu_mult_seq.sv
// Sequential 32x32 unsigned multiplier sequencer. Drives an external triple of
// 16x16 multiplier cells (1-clock latency) and returns either the low product
// word (MUL) or the unsigned high word (MULXUU).
// Optional feature macro: NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN. When undefined,
// MULXUU requests are answered immediately with rsp_err=1 and data 0.
module niosii_usb_cpu_cpu_mult_seq
    import niosii_usb_cpu_cpu_mult_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [DATA_W-1:0] cell_src1,
    output logic [DATA_W-1:0] cell_src2,
    output logic              cell_en,
    input  logic [DATA_W-1:0] cell_p1,
    input  logic [DATA_W-1:0] cell_p2,
    input  logic [DATA_W-1:0] cell_p3
);

    state_t state_q, state_d;

    logic load_req;
    logic cap_lo;
    logic op_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] lo_w;

`ifdef NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN
    logic cap_hi;
    // Only the operand upper halves are needed after the first cell pass;
    // the full operands live in the cell_src registers during ISS_LO.
    logic [HALF_W-1:0]  a_hi_q, b_hi_q;
    logic [CARRY_W-1:0] carry_q, carry_w;
    logic [DATA_W-1:0]  hi_q, hi_w;
`endif

    niosii_usb_cpu_cpu_mult_seq_comb u_comb (
        .p1       (cell_p1),
        .p2       (cell_p2),
        .p3       (cell_p3),
`ifdef NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN
        .carry_in (carry_q),
        .carry    (carry_w),
        .hi       (hi_w),
`endif
        .lo       (lo_w)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        load_req  = 1'b0;
        cap_lo    = 1'b0;
`ifdef NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN
        cap_hi    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    load_req = 1'b1;
`ifdef NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN
                    state_d  = S_ISS_LO;
`else
                    // Unsupported high-word request: skip the cells entirely.
                    state_d  = (req_op == OP_MULXUU) ? S_RESP : S_ISS_LO;
`endif
                end
            end
            S_ISS_LO: state_d = S_CAP_LO;
            S_CAP_LO: begin
                cap_lo = 1'b1;
`ifdef NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN
                state_d = (op_q == OP_MULXUU) ? S_ISS_HI : S_RESP;
`else
                state_d = S_RESP;
`endif
            end
`ifdef NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN
            S_ISS_HI: state_d = S_CAP_HI;
            S_CAP_HI: begin
                cap_hi  = 1'b1;
                state_d = S_RESP;
            end
`endif
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Cell operand/enable registers: loaded on entry to an issue state so the
    // cells see stable operands for the whole issue cycle, held otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cell_en   <= 1'b0;
            cell_src1 <= '0;
            cell_src2 <= '0;
        end else begin
            cell_en <= 1'b0;
            if (load_req && state_d == S_ISS_LO) begin
                cell_en   <= 1'b1;
                cell_src1 <= req_a;
                cell_src2 <= req_b;
            end
`ifdef NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN
            if (state_d == S_ISS_HI) begin
                cell_en   <= 1'b1;
                cell_src1 <= {{HALF_W{1'b0}}, a_hi_q};
                cell_src2 <= {{HALF_W{1'b0}}, b_hi_q};
            end
`endif
        end
    end

    // Request latch and result capture registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q    <= OP_MUL;
            lo_q    <= '0;
`ifdef NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN
            a_hi_q  <= '0;
            b_hi_q  <= '0;
            carry_q <= '0;
            hi_q    <= '0;
`endif
        end else begin
            if (load_req) begin
                op_q   <= req_op;
`ifdef NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN
                a_hi_q <= req_a[DATA_W-1:HALF_W];
                b_hi_q <= req_b[DATA_W-1:HALF_W];
`endif
            end
            if (cap_lo) begin
                lo_q    <= lo_w;
`ifdef NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN
                carry_q <= carry_w;
`endif
            end
`ifdef NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN
            if (cap_hi) hi_q <= hi_w;
`endif
        end
    end

`ifdef NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN
    assign rsp_data = (op_q == OP_MULXUU) ? hi_q : lo_q;
    assign rsp_err  = 1'b0;
`else
    assign rsp_data = (op_q == OP_MULXUU) ? '0 : lo_q;
    assign rsp_err  = (op_q == OP_MULXUU);
`endif

endmodule

// File: tb/tb_niosii_usb_cpu_cpu_mult_seq.sv
// Directed bench for the sequential multiplier, including a behavioural model
// of the external 16x16 cell triple.
module tb_niosii_usb_cpu_cpu_mult_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_op = 1'b0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] cell_src1, cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1 = '0, cell_p2 = '0, cell_p3 = '0;

    int checks = 0;
    int errors = 0;
    int cen_cnt = 0;
    int rsp_cnt = 0;

    always #5 clk = ~clk;

    niosii_usb_cpu_cpu_mult_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .cell_src1 (cell_src1),
        .cell_src2 (cell_src2),
        .cell_en   (cell_en),
        .cell_p1   (cell_p1),
        .cell_p2   (cell_p2),
        .cell_p3   (cell_p3)
    );

    // Cell triple model: one-clock registered 16x16 products.
    always @(posedge clk) begin
        if (cell_en) begin
            cell_p1 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[15:0]};
            cell_p2 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[31:16]};
            cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
        end
    end

    always @(posedge clk) begin
        if (cell_en)   cen_cnt <= cen_cnt + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    // Issue one request from IDLE with rsp_ready=1; returns at a falling edge
    // once the response handshake has completed.
    task automatic do_req(input logic op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] data, output logic err);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        data = rsp_data;
        err  = rsp_err;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        checks++; if (cell_en !== 1'b0) begin errors++; $display("FAIL reset_cell_en got %b want 0", cell_en); end
        checks++; if (cell_src1 !== 32'h0 || cell_src2 !== 32'h0) begin errors++; $display("FAIL reset_cell_src got %h/%h want 0/0", cell_src1, cell_src2); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        int lat; logic [31:0] d; logic e; int c0;
        c0 = cen_cnt;
        do_req(1'b0, 32'd3, 32'd5, lat, d, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL mul_latency got %0d want 3", lat); end
        checks++; if (d !== 32'h0000000F) begin errors++; $display("FAIL mul_3x5 got %h want 0000000f", d); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL mul_err got %b want 0", e); end
        checks++; if (cen_cnt - c0 !== 1) begin errors++; $display("FAIL mul_cell_en_pulses got %0d want 1", cen_cnt - c0); end
        checks++; if (cell_src1 !== 32'd3 || cell_src2 !== 32'd5) begin errors++; $display("FAIL mul_cell_src_hold got %h/%h want 3/5", cell_src1, cell_src2); end
        checks++; if (cell_en !== 1'b0) begin errors++; $display("FAIL mul_cell_en_idle got %b want 0", cell_en); end

        do_req(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, d, e);
        checks++; if (d !== 32'h00000001) begin errors++; $display("FAIL mul_ones got %h want 00000001", d); end
        do_req(1'b0, 32'h00010000, 32'h00010000, lat, d, e);
        checks++; if (d !== 32'h00000000) begin errors++; $display("FAIL mul_2p16 got %h want 00000000", d); end
        do_req(1'b0, 32'h12345678, 32'h9ABCDEF0, lat, d, e);
        checks++; if (d !== 32'h242D2080) begin errors++; $display("FAIL mul_mixed got %h want 242d2080", d); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL mul_mixed_latency got %0d want 3", lat); end
    endtask

`ifdef NIOSII_USB_CPU_MULT_SEQ_MULXUU_EN
    task automatic test_mulxuu();
        int lat; logic [31:0] d; logic e; int c0;
        c0 = cen_cnt;
        do_req(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, d, e);
        checks++; if (d !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulxuu_ones got %h want fffffffe", d); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL mulxuu_latency got %0d want 5", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL mulxuu_err got %b want 0", e); end
        checks++; if (cen_cnt - c0 !== 2) begin errors++; $display("FAIL mulxuu_cell_en_pulses got %0d want 2", cen_cnt - c0); end
        checks++; if (cell_src1 !== 32'h0000FFFF) begin errors++; $display("FAIL mulxuu_cell_src_hi got %h want 0000ffff", cell_src1); end
        do_req(1'b1, 32'h00010000, 32'h00010000, lat, d, e);
        checks++; if (d !== 32'h00000001) begin errors++; $display("FAIL mulxuu_2p16 got %h want 00000001", d); end
        do_req(1'b1, 32'h12345678, 32'h9ABCDEF0, lat, d, e);
        checks++; if (d !== 32'h0B00EA4E) begin errors++; $display("FAIL mulxuu_mixed got %h want 0b00ea4e", d); end
    endtask
`else
    task automatic test_mulxuu();
        int lat; logic [31:0] d; logic e; int c0;
        c0 = cen_cnt;
        do_req(1'b1, 32'd2, 32'd3, lat, d, e);
        checks++; if (lat !== 1) begin errors++; $display("FAIL mulxuu_off_latency got %0d want 1", lat); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL mulxuu_off_data got %h want 0", d); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL mulxuu_off_err got %b want 1", e); end
        checks++; if (cen_cnt - c0 !== 0) begin errors++; $display("FAIL mulxuu_off_cell_en got %0d pulses want 0", cen_cnt - c0); end
        do_req(1'b0, 32'd6, 32'd7, lat, d, e);
        checks++; if (d !== 32'd42 || e !== 1'b0) begin errors++; $display("FAIL mul_after_err got %h/%b want 0000002a/0", d, e); end
    endtask
`endif

    task automatic test_backpressure();
        int n; int c0; logic [31:0] d;
        rsp_ready = 1'b0;
        c0 = cen_cnt;
        req_valid = 1'b1; req_op = 1'b0; req_a = 32'h12345678; req_b = 32'h9ABCDEF0;
        @(posedge clk);
        @(negedge clk);
        // Keep requesting with different operands while busy.
        req_a = 32'hDEADBEEF; req_b = 32'h0BADF00D; req_op = 1'b1;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_timeout got %b want 1", rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_data !== 32'h242D2080) begin errors++; $display("FAIL bp_hold_data[%0d] got %h want 242d2080", i, rsp_data); end
            checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_ctrl[%0d] got rdy=%b vld=%b want 0/1", i, req_ready, rsp_valid); end
            @(negedge clk);
        end
        checks++; if (cen_cnt - c0 !== 1) begin errors++; $display("FAIL bp_cell_en_pulses got %0d want 1", cen_cnt - c0); end
        req_op = 1'b0; req_a = 32'd2; req_b = 32'd7;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_ready got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        d = rsp_data;
        checks++; if (n !== 3 || d !== 32'h0000000E) begin errors++; $display("FAIL bp_next_req got lat=%0d data=%h want 3/0000000e", n, d); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int r0; int lat; logic [31:0] d; logic e;
        r0 = rsp_cnt;
        req_valid = 1'b1; req_op = 1'b0; req_a = 32'h12345678; req_b = 32'h9ABCDEF0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        // Now in CAP_LO.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", req_ready); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL abort_rsp_data got %h want 0", rsp_data); end
        repeat (8) @(negedge clk);
        checks++; if (rsp_cnt - r0 !== 0) begin errors++; $display("FAIL abort_no_rsp got %0d responses want 0", rsp_cnt - r0); end
        do_req(1'b0, 32'd2, 32'd7, lat, d, e);
        checks++; if (d !== 32'h0000000E || lat !== 3) begin errors++; $display("FAIL abort_next_mul got %h lat=%0d want 0000000e lat=3", d, lat); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulxuu();
        test_backpressure();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
